// File: rtl/uart_pkg.sv
// Shared register map, STATUS/CTRL bit positions and FSM state encodings for the MMIO UART.
// Pure declarations: no logic, so no latency or backpressure of its own.
package uart_pkg;

    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_DVSR   = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;

    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_RX_FULL   = 2;
    localparam int ST_RX_EMPTY  = 3;
    localparam int ST_TX_BUSY   = 4;
    localparam int ST_OVERRUN   = 5;
    localparam int ST_FRAME_ERR = 6;

    localparam int CTRL_TX_EN      = 0;
    localparam int CTRL_RX_EN      = 1;
    localparam int CTRL_IRQ_RX_EN  = 2;
    localparam int CTRL_IRQ_TXE_EN = 3;

    typedef logic [1:0] tx_state_e;
    localparam tx_state_e TX_IDLE  = 2'd0;
    localparam tx_state_e TX_START = 2'd1;
    localparam tx_state_e TX_DATA  = 2'd2;
    localparam tx_state_e TX_STOP  = 2'd3;

    typedef logic [1:0] rx_state_e;
    localparam rx_state_e RX_IDLE  = 2'd0;
    localparam rx_state_e RX_START = 2'd1;
    localparam rx_state_e RX_DATA  = 2'd2;
    localparam rx_state_e RX_STOP  = 2'd3;

endpackage

// File: rtl/uart_mmio_periph_if.sv
// Data-memory bus port of the UART: one-cycle read/write strobes, combinational read data.
// No handshake: every strobe is accepted in the cycle it is presented.
interface uart_mmio_periph_if;
    logic [31:0] cpu_address;
    logic [31:0] cpu_data;
    logic        write_enable;
    logic        read_enable;
    logic [31:0] cpu_rdata;

    modport master (output cpu_address, cpu_data, write_enable, read_enable, input cpu_rdata);
    modport slave  (input cpu_address, cpu_data, write_enable, read_enable, output cpu_rdata);
endinterface

// File: rtl/uart_fifo.sv
// Show-ahead FIFO with wrap-bit pointers; head is valid combinationally whenever !empty.
// Push to a full FIFO is dropped unless a pop frees the slot in the same cycle; pop on empty is ignored.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: empty flags mask stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
    end

endmodule

// File: rtl/uart_mmio_periph.sv
// Memory-mapped full-duplex UART: baud-tick enable, TX/RX FSMs, TX/RX FIFOs, status/control and irq.
// Reads are combinational (0 latency); pushes to a full TX FIFO and RX bytes arriving at a full RX FIFO are dropped.
module uart_mmio_periph
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int DVSR_W     = 11,
    parameter int DVSR_RST   = 325
) (
    input  logic              clk,
    input  logic              reset,
    uart_mmio_periph_if.slave bus,
    input  logic              rx,
    output logic              tx,
    output logic              irq
);

    logic [2:0] reg_sel;
    logic       wr_data_sel, wr_status_sel, wr_dvsr_sel, wr_ctrl_sel, rd_data_sel;
    logic       unused_bus;

    assign reg_sel       = bus.cpu_address[4:2];
    assign wr_data_sel   = bus.write_enable && (reg_sel == REG_DATA);
    assign wr_status_sel = bus.write_enable && (reg_sel == REG_STATUS);
    assign wr_dvsr_sel   = bus.write_enable && (reg_sel == REG_DVSR);
    assign wr_ctrl_sel   = bus.write_enable && (reg_sel == REG_CTRL);
    assign rd_data_sel   = bus.read_enable  && (reg_sel == REG_DATA);
    assign unused_bus    = ^{bus.cpu_address[31:5], bus.cpu_address[1:0], bus.cpu_data};

    // Configuration and baud tick
    logic [DVSR_W-1:0] dvsr_q, dvsr_d, baud_cnt_q, baud_cnt_d;
    logic [3:0]        ctrl_q, ctrl_d;
    logic              tick;

    assign tick = (baud_cnt_q == dvsr_q);

    always_comb begin
        dvsr_d     = wr_dvsr_sel ? bus.cpu_data[DVSR_W-1:0] : dvsr_q;
        ctrl_d     = wr_ctrl_sel ? bus.cpu_data[3:0] : ctrl_q;
        baud_cnt_d = (tick || wr_dvsr_sel) ? '0 : baud_cnt_q + DVSR_W'(1);
    end

    // FIFOs
    logic            tx_fifo_full, tx_fifo_empty, tx_pop;
    logic            rx_fifo_full, rx_fifo_empty, rx_push;
    logic [DBIT-1:0] tx_head, rx_head;
    logic [DBIT-1:0] rx_b_q, rx_b_d;

    uart_fifo #(.WIDTH(DBIT), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (wr_data_sel),
        .wr_dat (bus.cpu_data[DBIT-1:0]),
        .pop    (tx_pop),
        .head   (tx_head),
        .full   (tx_fifo_full),
        .empty  (tx_fifo_empty)
    );

    uart_fifo #(.WIDTH(DBIT), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (rx_push),
        .wr_dat (rx_b_q),
        .pop    (rd_data_sel),
        .head   (rx_head),
        .full   (rx_fifo_full),
        .empty  (rx_fifo_empty)
    );

    // TX FSM: tx_d always carries the line level for the state being entered
    tx_state_e       tx_state_q, tx_state_d;
    logic [4:0]      tx_s_q, tx_s_d;
    logic [2:0]      tx_n_q, tx_n_d;
    logic [DBIT-1:0] tx_b_q, tx_b_d;
    logic            tx_q, tx_d;
    logic            tx_start_ok, tx_busy;

    assign tx_busy = (tx_state_q != TX_IDLE);
    assign tx      = tx_q;

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_s_d      = tx_s_q;
        tx_n_d      = tx_n_q;
        tx_b_d      = tx_b_q;
        tx_d        = tx_q;
        tx_pop      = 1'b0;
        tx_start_ok = ctrl_q[CTRL_TX_EN] && !tx_fifo_empty;
        case (tx_state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (tx_start_ok) begin
                    tx_state_d = TX_START;
                    tx_d       = 1'b0;
                    tx_s_d     = '0;
                    tx_b_d     = tx_head;
                    tx_pop     = 1'b1;
                end
            end
            TX_START: if (tick) begin
                if (tx_s_q == 5'd15) begin
                    tx_state_d = TX_DATA;
                    tx_s_d     = '0;
                    tx_n_d     = '0;
                    tx_d       = tx_b_q[0];
                end else begin
                    tx_s_d = tx_s_q + 5'd1;
                end
            end
            TX_DATA: if (tick) begin
                if (tx_s_q == 5'd15) begin
                    tx_s_d = '0;
                    tx_b_d = tx_b_q >> 1;
                    if (tx_n_q == 3'(DBIT - 1)) begin
                        tx_state_d = TX_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_n_d = tx_n_q + 3'd1;
                        tx_d   = tx_b_q[1];
                    end
                end else begin
                    tx_s_d = tx_s_q + 5'd1;
                end
            end
            TX_STOP: if (tick) begin
                if (tx_s_q == 5'(SB_TICK - 1)) begin
                    tx_s_d = '0;
                    // Chain straight into the next start bit so back-to-back frames have no idle gap
                    if (tx_start_ok) begin
                        tx_state_d = TX_START;
                        tx_d       = 1'b0;
                        tx_b_d     = tx_head;
                        tx_pop     = 1'b1;
                    end else begin
                        tx_state_d = TX_IDLE;
                        tx_d       = 1'b1;
                    end
                end else begin
                    tx_s_d = tx_s_q + 5'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // RX synchroniser and FSM
    logic       rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
    rx_state_e  rx_state_q, rx_state_d;
    logic [4:0] rx_s_q, rx_s_d;
    logic [2:0] rx_n_q, rx_n_d;
    logic       overrun_set, frame_err_set;

    always_comb begin
        rx_meta_d     = rx;
        rx_sync_d     = rx_meta_q;
        rx_prev_d     = rx_sync_q;
        rx_state_d    = rx_state_q;
        rx_s_d        = rx_s_q;
        rx_n_d        = rx_n_q;
        rx_b_d        = rx_b_q;
        rx_push       = 1'b0;
        overrun_set   = 1'b0;
        frame_err_set = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (ctrl_q[CTRL_RX_EN] && rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_s_d     = '0;
                end
            end
            RX_START: if (tick) begin
                // Mid start bit: a line already back high was a glitch
                if (rx_s_q == 5'd7) begin
                    rx_s_d     = '0;
                    rx_n_d     = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_s_d = rx_s_q + 5'd1;
                end
            end
            RX_DATA: if (tick) begin
                if (rx_s_q == 5'd15) begin
                    rx_s_d = '0;
                    rx_b_d = {rx_sync_q, rx_b_q[DBIT-1:1]};
                    if (rx_n_q == 3'(DBIT - 1)) rx_state_d = RX_STOP;
                    else                        rx_n_d     = rx_n_q + 3'd1;
                end else begin
                    rx_s_d = rx_s_q + 5'd1;
                end
            end
            RX_STOP: if (tick) begin
                if (rx_s_q == 5'(SB_TICK - 1)) begin
                    rx_s_d     = '0;
                    rx_state_d = RX_IDLE;
                    if (!rx_sync_q)                       frame_err_set = 1'b1;
                    else if (rx_fifo_full && !rd_data_sel) overrun_set   = 1'b1;
                    else                                   rx_push       = 1'b1;
                end else begin
                    rx_s_d = rx_s_q + 5'd1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Sticky error flags: a set in the same cycle as a W1C wins
    logic overrun_q, overrun_d, frame_err_q, frame_err_d;

    always_comb begin
        overrun_d   = overrun_set |
                      (overrun_q & ~(wr_status_sel & bus.cpu_data[ST_OVERRUN]));
        frame_err_d = frame_err_set |
                      (frame_err_q & ~(wr_status_sel & bus.cpu_data[ST_FRAME_ERR]));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dvsr_q      <= DVSR_W'(DVSR_RST);
            ctrl_q      <= 4'b0011;
            baud_cnt_q  <= '0;
            tx_state_q  <= TX_IDLE;
            tx_s_q      <= '0;
            tx_n_q      <= '0;
            tx_b_q      <= '0;
            tx_q        <= 1'b1;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_s_q      <= '0;
            rx_n_q      <= '0;
            rx_b_q      <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            dvsr_q      <= dvsr_d;
            ctrl_q      <= ctrl_d;
            baud_cnt_q  <= baud_cnt_d;
            tx_state_q  <= tx_state_d;
            tx_s_q      <= tx_s_d;
            tx_n_q      <= tx_n_d;
            tx_b_q      <= tx_b_d;
            tx_q        <= tx_d;
            rx_meta_q   <= rx_meta_d;
            rx_sync_q   <= rx_sync_d;
            rx_prev_q   <= rx_prev_d;
            rx_state_q  <= rx_state_d;
            rx_s_q      <= rx_s_d;
            rx_n_q      <= rx_n_d;
            rx_b_q      <= rx_b_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Readback
    logic [31:0] status;

    always_comb begin
        status               = '0;
        status[ST_TX_FULL]   = tx_fifo_full;
        status[ST_TX_EMPTY]  = tx_fifo_empty;
        status[ST_RX_FULL]   = rx_fifo_full;
        status[ST_RX_EMPTY]  = rx_fifo_empty;
        status[ST_TX_BUSY]   = tx_busy;
        status[ST_OVERRUN]   = overrun_q;
        status[ST_FRAME_ERR] = frame_err_q;
    end

    always_comb begin
        bus.cpu_rdata = '0;
        case (reg_sel)
            REG_DATA:   if (!rx_fifo_empty) bus.cpu_rdata = {{(32-DBIT){1'b0}}, rx_head};
            REG_STATUS: bus.cpu_rdata = status;
            REG_DVSR:   bus.cpu_rdata = {{(32-DVSR_W){1'b0}}, dvsr_q};
            REG_CTRL:   bus.cpu_rdata = {28'd0, ctrl_q};
            default:    bus.cpu_rdata = '0;
        endcase
    end

    assign irq = (ctrl_q[CTRL_IRQ_RX_EN]  & ~rx_fifo_empty) |
                 (ctrl_q[CTRL_IRQ_TXE_EN] & tx_fifo_empty & ~tx_busy) |
                 overrun_q | frame_err_q;

endmodule

// File: tb/tb_uart_mmio_periph.sv
// Directed bench for uart_mmio_periph at DVSR=3 (64 clk per bit): TX framing, back-to-back, loopback overrun,
// framing error, glitch rejection and mid-frame reset.
module tb_uart_mmio_periph;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx_drv = 1'b1;
    logic loop_en = 1'b0;
    logic rx, tx, irq;
    int   n_cmp = 0;
    int   n_bad = 0;

    uart_mmio_periph_if bus();

    assign rx = loop_en ? tx : rx_drv;

    uart_mmio_periph dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .rx    (rx),
        .tx    (tx),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.cpu_address  = a;
        bus.cpu_data     = d;
        bus.write_enable = 1'b1;
        @(posedge clk);
        #1 bus.write_enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus.cpu_address = a;
        bus.read_enable = 1'b1;
        #1 d = bus.cpu_rdata;
        @(posedge clk);
        #1 bus.read_enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_tx_low(input int limit, output int waited, output bit seen);
        waited = 0;
        seen   = 1'b0;
        while (!seen && waited < limit) begin
            if (tx === 1'b0) seen = 1'b1;
            else begin
                @(negedge clk);
                waited++;
            end
        end
    endtask

    // Entered on the first negedge with tx low; samples each bit at its centre.
    task automatic capture_frame(output logic [9:0] f);
        repeat (32) @(negedge clk);
        f[0] = tx;
        for (int k = 1; k < 10; k++) begin
            repeat (64) @(negedge clk);
            f[k] = tx;
        end
    endtask

    task automatic wait_tx_idle(input int limit, output bit ok);
        logic [31:0] d;
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            bus_read(32'h04, d);
            if (d[4] === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic send_rx_frame(input logic [7:0] b, input logic stop);
        rx_drv = 1'b0;
        repeat (64) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx_drv = b[k];
            repeat (64) @(negedge clk);
        end
        rx_drv = stop;
        repeat (64) @(negedge clk);
        rx_drv = 1'b1;
        repeat (64) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        repeat (3) @(negedge clk);
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b, required 1", tx); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b, required 0", irq); end
        reset = 1'b0;
        @(negedge clk);
        bus_read(32'h04, d);
        n_cmp++; if (d !== 32'h0A) begin n_bad++; $display("FAIL reset_status: got %h, required 0000000a", d); end
        bus_read(32'h08, d);
        n_cmp++; if (d !== 32'd325) begin n_bad++; $display("FAIL reset_dvsr: got %0d, required 325", d); end
        bus_read(32'h0C, d);
        n_cmp++; if (d !== 32'h3) begin n_bad++; $display("FAIL reset_ctrl: got %h, required 3", d); end
        bus_read(32'h00, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_data_empty: got %h, required 0", d); end
        bus_read(32'h10, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL unmapped_read: got %h, required 0", d); end
    endtask

    task automatic test_tx_single;
        logic [31:0] d;
        logic [9:0]  f;
        int          w;
        bit          seen, ok;
        bus_write(32'h08, 32'd3);
        bus_write(32'h0C, 32'h1);
        bus_read(32'h08, d);
        n_cmp++; if (d !== 32'd3) begin n_bad++; $display("FAIL dvsr_rw: got %0d, required 3", d); end
        bus_write(32'h00, 32'h55);
        wait_tx_low(200, w, seen);
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL tx_start: tx stayed %b, required 0 within 200 cycles", tx); end
        else begin
            capture_frame(f);
            n_cmp++; if (f !== {1'b1, 8'h55, 1'b0}) begin n_bad++; $display("FAIL tx_frame_55: got %b, required %b", f, {1'b1, 8'h55, 1'b0}); end
            bus_read(32'h04, d);
            n_cmp++; if (d[4] !== 1'b1) begin n_bad++; $display("FAIL tx_busy_stop: got %b, required 1", d[4]); end
        end
        wait_tx_idle(200, ok);
        bus_read(32'h04, d);
        n_cmp++; if (d !== 32'h0A) begin n_bad++; $display("FAIL tx_done_status: got %h, required 0000000a", d); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        logic [9:0]  f;
        logic [7:0]  exp_b [3];
        int          gap;
        bit          seen, ok;
        exp_b = '{8'hA1, 8'hB2, 8'hC3};
        bus_write(32'h00, 32'hA1);
        bus_write(32'h00, 32'hB2);
        bus_write(32'h00, 32'hC3);
        bus_read(32'h04, d);
        n_cmp++; if ({d[4], d[1]} !== 2'b10) begin n_bad++; $display("FAIL b2b_queued: busy,tx_empty got %b%b, required 10", d[4], d[1]); end
        for (int k = 0; k < 3; k++) begin
            wait_tx_low(100, gap, seen);
            n_cmp++;
            if (!seen) begin n_bad++; $display("FAIL b2b_start frame %0d: no start bit within 100 cycles", k); end
            else begin
                if (k > 0) begin
                    n_cmp++; if (gap > 32) begin n_bad++; $display("FAIL b2b_gap frame %0d: got %0d cycles, required <= 32", k, gap); end
                end
                capture_frame(f);
                n_cmp++; if (f !== {1'b1, exp_b[k], 1'b0}) begin n_bad++; $display("FAIL b2b_frame %0d: got %b, required %b", k, f, {1'b1, exp_b[k], 1'b0}); end
            end
        end
        wait_tx_idle(200, ok);
        bus_read(32'h04, d);
        n_cmp++; if (d !== 32'h0A) begin n_bad++; $display("FAIL b2b_drained: got %h, required 0000000a", d); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL b2b_irq_masked: got %b, required 0", irq); end
        bus_write(32'h0C, 32'h9);
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL b2b_irq_txe: got %b, required 1", irq); end
    endtask

    task automatic test_overrun;
        logic [31:0] d;
        logic [7:0]  b;
        bit          got, ok;
        bus_write(32'h0C, 32'h3);
        loop_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            b = 8'(i * 13 + 5);
            bus_write(32'h00, {24'd0, b});
            if (i == 0) repeat (2) @(negedge clk);
        end
        got = 1'b0;
        for (int i = 0; i < 13000 && !got; i++) begin
            bus_read(32'h04, d);
            if (d[5] === 1'b1) got = 1'b1;
        end
        n_cmp++;
        if (!got) begin n_bad++; $display("FAIL overrun_wait: overrun got %b, required 1 within 13000 reads", d[5]); end
        n_cmp++; if ({d[6], d[5], d[3], d[2]} !== 4'b0101) begin n_bad++; $display("FAIL overrun_status: ferr,ovr,rxe,rxf got %b, required 0101", {d[6], d[5], d[3], d[2]}); end
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL overrun_irq: got %b, required 1", irq); end
        for (int i = 0; i < 16; i++) begin
            b = 8'(i * 13 + 5);
            bus_read(32'h00, d);
            n_cmp++; if (d !== {24'd0, b}) begin n_bad++; $display("FAIL loop_read %0d: got %h, required %h", i, d, b); end
        end
        bus_read(32'h04, d);
        n_cmp++; if ({d[3], d[2]} !== 2'b10) begin n_bad++; $display("FAIL loop_drained: rxe,rxf got %b, required 10", {d[3], d[2]}); end
        bus_read(32'h00, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL pop_empty: got %h, required 0", d); end
        wait_tx_idle(200, ok);
        loop_en = 1'b0;
        bus_write(32'h04, 32'h20);
        bus_read(32'h04, d);
        n_cmp++; if (d !== 32'h0A) begin n_bad++; $display("FAIL overrun_w1c: got %h, required 0000000a", d); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL overrun_irq_clear: got %b, required 0", irq); end
    endtask

    task automatic test_frame_err;
        logic [31:0] d;
        send_rx_frame(8'h3C, 1'b0);
        bus_read(32'h04, d);
        n_cmp++; if ({d[6], d[3]} !== 2'b11) begin n_bad++; $display("FAIL frame_err_status: ferr,rxe got %b, required 11", {d[6], d[3]}); end
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL frame_err_irq: got %b, required 1", irq); end
        bus_write(32'h04, 32'h40);
        bus_read(32'h04, d);
        n_cmp++; if (d !== 32'h0A) begin n_bad++; $display("FAIL frame_err_w1c: got %h, required 0000000a", d); end
    endtask

    task automatic test_glitch;
        logic [31:0] d;
        rx_drv = 1'b0;
        repeat (16) @(negedge clk);
        rx_drv = 1'b1;
        repeat (700) @(negedge clk);
        bus_read(32'h04, d);
        n_cmp++; if (d !== 32'h0A) begin n_bad++; $display("FAIL glitch_status: got %h, required 0000000a", d); end
        send_rx_frame(8'hC3, 1'b1);
        bus_read(32'h04, d);
        n_cmp++; if ({d[6], d[5], d[3]} !== 3'b000) begin n_bad++; $display("FAIL glitch_then_rx: ferr,ovr,rxe got %b, required 000", {d[6], d[5], d[3]}); end
        bus_read(32'h00, d);
        n_cmp++; if (d !== 32'hC3) begin n_bad++; $display("FAIL glitch_then_rx_data: got %h, required c3", d); end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] d;
        int          w;
        bit          seen;
        bus_write(32'h00, 32'h00);
        wait_tx_low(200, w, seen);
        repeat (100) @(negedge clk);
        n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL mid_frame_tx: got %b, required 0", tx); end
        reset = 1'b1;
        #1;
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL async_reset_tx: got %b, required 1", tx); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        bus_read(32'h08, d);
        n_cmp++; if (d !== 32'd325) begin n_bad++; $display("FAIL mid_reset_dvsr: got %0d, required 325", d); end
        bus_read(32'h04, d);
        n_cmp++; if (d !== 32'h0A) begin n_bad++; $display("FAIL mid_reset_status: got %h, required 0000000a", d); end
        bus_read(32'h0C, d);
        n_cmp++; if (d !== 32'h3) begin n_bad++; $display("FAIL mid_reset_ctrl: got %h, required 3", d); end
        repeat (100) @(negedge clk);
        n_cmp++; if ({tx, irq} !== 2'b10) begin n_bad++; $display("FAIL mid_reset_idle: tx,irq got %b, required 10", {tx, irq}); end
    endtask

    initial begin
        bus.cpu_address  = '0;
        bus.cpu_data     = '0;
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b0;
        @(negedge clk);
        test_reset();
        test_tx_single();
        test_back_to_back();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
